// File: rtl/program_loader_module_if.sv
// Byte-source handshake and shared-bus control lines between the program loader and its neighbours.
// The loader uses the master modport; the byte source, arbiter and RAM side use the slave modport.
interface program_loader_module_if;
  logic [7:0] byte_i;
  logic       byte_valid;
  logic       byte_ready;
  logic       bus_req;
  logic       bus_gnt;
  logic       mai;
  logic       mi;
  logic       mo;

  modport master (
    input  byte_i, byte_valid, bus_gnt,
    output byte_ready, bus_req, mai, mi, mo
  );

  modport slave (
    output byte_i, byte_valid, bus_gnt,
    input  byte_ready, bus_req, mai, mi, mo
  );
endinterface

// File: rtl/program_loader_module.sv
// Bus-master program loader: takes bytes from a valid/ready source and writes them to RAM via mai/mi.
// Define LOADER_VERIFY_EN to add a read-back VERIFY state (mo) that flags mismatches on error.
module program_loader_module #(
  parameter int MEM_DEPTH  = 16,
  parameter int START_ADDR = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  program_loader_module_if.master lif,
  inout  wire  [7:0]              bus,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [7:0]              count
);
  localparam logic [8:0] DEPTH = 9'(MEM_DEPTH);
  localparam logic [7:0] ADDR0 = 8'(START_ADDR);

`ifdef LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ADDR, S_DATA, S_DONE, S_VERIFY} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_ADDR, S_DATA, S_DONE} state_e;
`endif

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] count_q, count_d;
  logic [7:0] bus_out_q, bus_out_d;
  logic       held_q, held_d;
  logic       rdy_q, rdy_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       mai_q, mai_d;
  logic       mi_q, mi_d;
  logic       drv_q, drv_d;
  logic       gnt;
  logic       last;
`ifdef LOADER_VERIFY_EN
  logic       mo_q, mo_d;
  logic       error_q, error_d;
`endif

  assign gnt = lif.bus_gnt;

`ifdef LOADER_VERIFY_EN
  // evaluated in VERIFY, where count already includes the byte just written
  assign last = (count_q == DEPTH[7:0]);
`else
  assign last = (({1'b0, count_q} + 9'd1) == DEPTH);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    count_d = count_q;
    held_d  = held_q;
`ifdef LOADER_VERIFY_EN
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_REQ;
          addr_d  = ADDR0;
          count_d = '0;
          held_d  = 1'b0;
`ifdef LOADER_VERIFY_EN
          error_d = 1'b0;
`endif
        end
      end
      // a byte still held after a lost grant is replayed from ADDR
      S_REQ: if (gnt) state_d = held_q ? S_ADDR : S_WAIT;
      S_WAIT: begin
        if (!gnt) state_d = S_REQ;
        else if (lif.byte_valid) begin
          data_d  = lif.byte_i;
          held_d  = 1'b1;
          state_d = S_ADDR;
        end
      end
      S_ADDR: state_d = gnt ? S_DATA : S_REQ;
      S_DATA: begin
        if (!gnt) state_d = S_REQ;
        else begin
          count_d = count_q + 8'd1;
          addr_d  = addr_q + 8'd1;
          held_d  = 1'b0;
`ifdef LOADER_VERIFY_EN
          state_d = S_VERIFY;
`else
          state_d = last ? S_DONE : S_WAIT;
`endif
        end
      end
`ifdef LOADER_VERIFY_EN
      S_VERIFY: begin
        if (gnt && (bus != data_q)) error_d = 1'b1;
        if (last)     state_d = S_DONE;
        else if (gnt) state_d = S_WAIT;
        else          state_d = S_REQ;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // outputs are registered from the next state so they line up with state_q
    rdy_d     = (state_d == S_WAIT);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE));
    done_d    = (state_d == S_DONE);
    mai_d     = (state_d == S_ADDR);
    mi_d      = (state_d == S_DATA);
    drv_d     = mai_d | mi_d;
    bus_out_d = mai_d ? addr_d : data_d;
`ifdef LOADER_VERIFY_EN
    mo_d      = (state_d == S_VERIFY);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      count_q   <= '0;
      bus_out_q <= '0;
      held_q    <= 1'b0;
      rdy_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mai_q     <= 1'b0;
      mi_q      <= 1'b0;
      drv_q     <= 1'b0;
`ifdef LOADER_VERIFY_EN
      mo_q      <= 1'b0;
      error_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      count_q   <= count_d;
      bus_out_q <= bus_out_d;
      held_q    <= held_d;
      rdy_q     <= rdy_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mai_q     <= mai_d;
      mi_q      <= mi_d;
      drv_q     <= drv_d;
`ifdef LOADER_VERIFY_EN
      mo_q      <= mo_d;
      error_q   <= error_d;
`endif
    end
  end

  // grant loss must release the bus in the same cycle, so strobes and drive are gated by bus_gnt
  assign lif.byte_ready = rdy_q & gnt;
  assign lif.bus_req    = busy_q;
  assign lif.mai        = mai_q & gnt;
  assign lif.mi         = mi_q & gnt;
  assign bus            = (drv_q && gnt) ? bus_out_q : 8'bz;
  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;
`ifdef LOADER_VERIFY_EN
  assign lif.mo         = mo_q & gnt;
  assign error          = error_q;
`else
  assign lif.mo         = 1'b0;
  assign error          = 1'b0;
`endif
endmodule

// File: tb/tb_program_loader_module.sv
// Bench for program_loader_module: RAM/MAR model on the shared bus plus a write scoreboard.
// Covers reset, full load, delayed grant, grant loss in DATA, mid-load reset and (if compiled) verify.
module tb_program_loader_module;
  localparam int         MEM_DEPTH  = 16;
  localparam logic [7:0] START_ADDR = 8'h00;

  logic       clk = 1'b0;
  logic       rst, start;
  wire  [7:0] bus;
  logic       busy, done, error;
  logic [7:0] count;

  program_loader_module_if lif();

  program_loader_module #(.MEM_DEPTH(MEM_DEPTH), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .start(start), .lif(lif.master), .bus(bus),
    .busy(busy), .done(done), .error(error), .count(count)
  );

  always #5 clk = ~clk;

  logic       probe_en, stuck2;
  logic [7:0] ram [256];
  logic [7:0] mar;
  logic [7:0] exp_addr;
  logic [15:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  // probe: reads back 0xA5 only while nobody else drives the bus
  assign bus = probe_en ? 8'hA5 : 8'bz;
  assign bus = lif.mo ? ram[mar] : 8'bz;

  // one clock: model MAR/RAM at the rising edge, score writes, end on the falling edge
  task automatic tick();
    logic [15:0] e;
    @(posedge clk);
    if (lif.mai) mar = bus;
    if (lif.mi) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ram_write unexpected write got addr=%h data=%h", mar, bus);
      end else begin
        e = exp_q.pop_front();
        if ({mar, bus} !== e) begin
          errors++;
          $display("FAIL ram_write got addr=%h data=%h exp addr=%h data=%h", mar, bus, e[15:8], e[7:0]);
        end
      end
      ram[mar] = (stuck2 && mar == 8'd2) ? 8'h00 : bus;
    end
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    exp_addr = START_ADDR;
    tick();
    start = 1'b0;
  endtask

  // presents one byte; returns on the falling edge after the handshake (loader in ADDR)
  task automatic drive_byte(input logic [7:0] b);
    bit ok = 1'b0;
    lif.byte_i = b;
    lif.byte_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (lif.byte_ready) begin
        exp_q.push_back({exp_addr, b});
        exp_addr = exp_addr + 8'd1;
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    lif.byte_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL handshake timeout byte=%h got ready=0 exp ready=1", b); end
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (done) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL done_timeout got done=0 exp done=1"); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; probe_en = 1'b1; stuck2 = 1'b0;
    lif.byte_valid = 1'b0; lif.byte_i = 8'h00; lif.bus_gnt = 1'b1;
    tick(); tick(); #1;
    checks++;
    if ({lif.byte_ready, lif.bus_req, lif.mai, lif.mi, lif.mo, busy, done, error} !== 8'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy/req/mai/mi/mo/busy/done/err=%b count=%0d exp all 0", {lif.byte_ready, lif.bus_req, lif.mai, lif.mi, lif.mo, busy, done, error}, count);
    end
    checks++;
    if (bus !== 8'hA5) begin errors++; $display("FAIL reset_bus_z got %h exp %h (undriven)", bus, 8'hA5); end
    rst = 1'b0; probe_en = 1'b0;
    tick();
  endtask

  task automatic test_load_basic();
    logic [7:0] d;
    lif.bus_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      d = 8'(8'h10 + i);
      drive_byte(d);
      if (i == 0) begin
        #1;
        checks++;
        if (lif.mai !== 1'b1 || lif.mi !== 1'b0 || bus !== START_ADDR) begin
          errors++; $display("FAIL first_addr got mai=%b mi=%b bus=%h exp mai=1 mi=0 bus=%h", lif.mai, lif.mi, bus, START_ADDR);
        end
        checks++;
        if (lif.byte_ready !== 1'b0) begin errors++; $display("FAIL ready_outside_wait got %b exp 0", lif.byte_ready); end
        tick(); #1;
        checks++;
        if (lif.mai !== 1'b0 || lif.mi !== 1'b1 || bus !== 8'h10) begin
          errors++; $display("FAIL first_data got mai=%b mi=%b bus=%h exp mai=0 mi=1 bus=10", lif.mai, lif.mi, bus);
        end
      end
      if (i == 8) begin start = 1'b1; tick(); start = 1'b0; end
    end
    wait_done(); #1;
    checks++;
    if (done !== 1'b1 || count !== 8'd16 || lif.bus_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL load_end got done=%b count=%0d req=%b busy=%b exp 1 16 0 0", done, count, lif.bus_req, busy);
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      checks++;
      if (ram[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL ram_image[%0d] got %h exp %h", i, ram[i], 8'(8'h10 + i)); end
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL load_pending got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_no_grant();
    lif.bus_gnt = 1'b0; probe_en = 1'b1;
    lif.byte_valid = 1'b1; lif.byte_i = 8'h77;
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (lif.bus_req !== 1'b1 || lif.byte_ready !== 1'b0 || bus !== 8'hA5 || lif.mai !== 1'b0 || lif.mi !== 1'b0) begin
        errors++; $display("FAIL no_grant cyc%0d got req=%b rdy=%b bus=%h mai=%b mi=%b exp 1 0 a5 0 0", k, lif.bus_req, lif.byte_ready, bus, lif.mai, lif.mi);
      end
      tick();
    end
    lif.byte_valid = 1'b0; probe_en = 1'b0; lif.bus_gnt = 1'b1;
    for (int i = 0; i < MEM_DEPTH; i++) drive_byte(8'(8'hC0 ^ (i * 7)));
    wait_done(); #1;
    checks++;
    if (count !== 8'd16 || done !== 1'b1) begin errors++; $display("FAIL no_grant_end got count=%0d done=%b exp 16 1", count, done); end
    checks++;
    if (ram[5] !== 8'(8'hC0 ^ 35)) begin errors++; $display("FAIL no_grant_ram5 got %h exp %h", ram[5], 8'(8'hC0 ^ 35)); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL no_grant_pending got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_grant_drop();
    lif.bus_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      drive_byte(8'(8'h40 + 2 * i));
      if (i == 3) begin
        tick();
        lif.bus_gnt = 1'b0; probe_en = 1'b1; #1;
        checks++;
        if (lif.mi !== 1'b0 || lif.mai !== 1'b0 || bus !== 8'hA5) begin
          errors++; $display("FAIL drop_in_data got mi=%b mai=%b bus=%h exp 0 0 a5", lif.mi, lif.mai, bus);
        end
        tick(); #1;
        checks++;
        if (lif.bus_req !== 1'b1 || lif.byte_ready !== 1'b0 || lif.mi !== 1'b0 || count !== 8'd3) begin
          errors++; $display("FAIL drop_req got req=%b rdy=%b mi=%b count=%0d exp 1 0 0 3", lif.bus_req, lif.byte_ready, lif.mi, count);
        end
        tick();
        probe_en = 1'b0; lif.bus_gnt = 1'b1;
      end
    end
    wait_done(); #1;
    checks++;
    if (ram[3] !== 8'h46 || count !== 8'd16) begin errors++; $display("FAIL drop_end got ram3=%h count=%0d exp 46 16", ram[3], count); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drop_pending got %0d exp 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    lif.bus_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < 6; i++) drive_byte(8'(8'h60 + i));
    rst = 1'b1; probe_en = 1'b1;
    tick(); #1;
    checks++;
    if ({lif.byte_ready, lif.bus_req, lif.mai, lif.mi, lif.mo, busy, done, error} !== 8'b0 || count !== 8'd0 || bus !== 8'hA5) begin
      errors++; $display("FAIL mid_reset got outs=%b count=%0d bus=%h exp 0 0 a5", {lif.byte_ready, lif.bus_req, lif.mai, lif.mi, lif.mo, busy, done, error}, count, bus);
    end
    rst = 1'b0; probe_en = 1'b0;
    checks++;
    if (exp_q.size() != 1) begin errors++; $display("FAIL mid_reset_pending got %0d exp 1", exp_q.size()); end
    exp_q.delete();
    pulse_start(); #1;
    checks++;
    if (count !== 8'd0 || busy !== 1'b1) begin errors++; $display("FAIL restart got count=%0d busy=%b exp 0 1", count, busy); end
    for (int i = 0; i < MEM_DEPTH; i++) drive_byte(8'(8'h90 + i));
    wait_done(); #1;
    checks++;
    if (count !== 8'd16 || ram[0] !== 8'h90 || ram[15] !== 8'h9F) begin
      errors++; $display("FAIL restart_end got count=%0d ram0=%h ram15=%h exp 16 90 9f", count, ram[0], ram[15]);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL restart_pending got %0d exp 0", exp_q.size()); end
  endtask

`ifdef LOADER_VERIFY_EN
  task automatic test_verify();
    stuck2 = 1'b1; lif.bus_gnt = 1'b1;
    pulse_start();
    for (int i = 0; i < MEM_DEPTH; i++) begin
      drive_byte(8'hAA);
      if (i == 2) begin
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL verify_before got error=%b exp 0", error); end
      end
      if (i == 3) begin
        checks++;
        if (error !== 1'b1) begin errors++; $display("FAIL verify_after got error=%b exp 1", error); end
      end
    end
    wait_done(); #1;
    checks++;
    if (done !== 1'b1 || error !== 1'b1 || count !== 8'd16) begin
      errors++; $display("FAIL verify_end got done=%b error=%b count=%0d exp 1 1 16", done, error, count);
    end
    stuck2 = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load_basic();
    test_no_grant();
    test_grant_drop();
    test_reset_mid();
`ifdef LOADER_VERIFY_EN
    test_verify();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
